// File: rtl/adc_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_scan_sequencer
// Brief    : Steps the ADC channel select through an enabled-channel mask, drops
//            settling/stale samples and banks one 10-bit result per channel.
//            Optional build macro ADC_AVG_EN averages 2^AVG_LOG2 samples/channel.
// Revision : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
    parameter int DISCARD     = 1,
    parameter int TIMEOUT_CYC = 50000,
    parameter int AVG_LOG2    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    input  logic [15:0] chan_mask,
    output logic [3:0]  channel,
    input  logic        new_sample,
    input  logic [9:0]  sample,
    input  logic [3:0]  sample_chan,
    input  logic [3:0]  rd_ch,
    output logic [9:0]  rd_data,
    output logic [15:0] valid,
    output logic [15:0] timeout_err,
    output logic        busy,
    output logic        scan_done
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    generate
        if (DISCARD < 0 || DISCARD > 15) begin : g_chk_discard
            $error("DISCARD out of range 0..15");
        end
        if (TIMEOUT_CYC < 2) begin : g_chk_timeout
            $error("TIMEOUT_CYC must be >= 2");
        end
        if (AVG_LOG2 < 1 || AVG_LOG2 > 4) begin : g_chk_avg
            $error("AVG_LOG2 out of range 1..4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEEK   = 3'd1,
        S_SETTLE = 3'd2,
        S_ACQ    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t       r_state;
    logic [14:0]  r_scan_mask;
    logic [4:0]   r_idx;
    logic [3:0]   r_channel;
    logic [3:0]   r_disc_cnt;
    logic [TW-1:0] r_timer;
    logic         r_busy;
    logic         r_scan_done;
    logic [15:0]  r_valid;
    logic [15:0]  r_timeout_err;
    logic [9:0]   r_rd_data;
    logic [9:0]   r_bank [0:14];

    logic [15:0]  w_mask_in;
    logic         w_found;
    logic [3:0]   w_next_ch;
    logic         w_match;
    logic         w_timeout;
    logic [4:0]   w_next_idx;
    logic [3:0]   w_disc_next;
    logic         w_acq_last;
    logic [9:0]   w_store_val;

    assign w_mask_in   = chan_mask & 16'h7FFF;
    assign w_match     = new_sample && (sample_chan == r_channel);
    assign w_timeout   = (r_timer == TW'(TIMEOUT_CYC - 1));
    assign w_next_idx  = {1'b0, r_channel} + 5'd1;
    assign w_disc_next = r_disc_cnt + 4'd1;

    // Lowest enabled channel at or above the resume index.
    always_comb begin
        w_found   = 1'b0;
        w_next_ch = 4'd0;
        for (int i = 14; i >= 0; i--) begin
            if (r_scan_mask[i] && (5'(i) >= r_idx)) begin
                w_found   = 1'b1;
                w_next_ch = 4'(i);
            end
        end
    end

`ifdef ADC_AVG_EN
    logic [9+AVG_LOG2:0]  r_acc;
    logic [AVG_LOG2-1:0]  r_acc_cnt;
    logic [9+AVG_LOG2:0]  w_sum;

    assign w_sum       = r_acc + {{AVG_LOG2{1'b0}}, sample};
    assign w_acq_last  = &r_acc_cnt;
    assign w_store_val = w_sum[9+AVG_LOG2:AVG_LOG2];

    // Every exit from ACQ passes through SEEK, which discards any partial sum.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_SEEK) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (r_state == S_ACQ && w_match) begin
            r_acc     <= w_sum;
            r_acc_cnt <= r_acc_cnt + 1'b1;
        end
    end
`else
    assign w_acq_last  = 1'b1;
    assign w_store_val = sample;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_scan_mask   <= '0;
            r_idx         <= '0;
            r_channel     <= 4'hF;
            r_disc_cnt    <= '0;
            r_timer       <= '0;
            r_busy        <= 1'b0;
            r_scan_done   <= 1'b0;
            r_valid       <= '0;
            r_timeout_err <= '0;
            r_rd_data     <= '0;
            for (int i = 0; i < 15; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            r_scan_done <= 1'b0;
            r_rd_data   <= (rd_ch == 4'hF) ? 10'd0 : r_bank[rd_ch];
            if (r_state == S_SETTLE || r_state == S_ACQ) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && (w_mask_in != 16'd0)) begin
                        r_scan_mask <= w_mask_in[14:0];
                        r_idx       <= 5'd0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (!w_found) begin
                        r_scan_done <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_channel  <= w_next_ch;
                        r_disc_cnt <= 4'd0;
                        r_timer    <= '0;
                        r_state    <= (DISCARD == 0) ? S_ACQ : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_timeout) begin
                        r_timeout_err[r_channel] <= 1'b1;
                        r_idx                    <= w_next_idx;
                        r_state                  <= S_SEEK;
                    end else if (w_match) begin
                        r_disc_cnt <= w_disc_next;
                        if (w_disc_next == 4'(DISCARD)) begin
                            r_state <= S_ACQ;
                        end
                    end
                end
                S_ACQ: begin
                    // A completing sample on the timeout cycle still counts.
                    if (w_match && w_acq_last) begin
                        r_bank[r_channel]        <= w_store_val;
                        r_valid[r_channel]       <= 1'b1;
                        r_timeout_err[r_channel] <= 1'b0;
                        r_idx                    <= w_next_idx;
                        r_state                  <= S_SEEK;
                    end else if (w_timeout) begin
                        r_timeout_err[r_channel] <= 1'b1;
                        r_idx                    <= w_next_idx;
                        r_state                  <= S_SEEK;
                    end
                end
                S_DONE: begin
                    if (continuous && (w_mask_in != 16'd0)) begin
                        r_scan_mask <= w_mask_in[14:0];
                        r_idx       <= 5'd0;
                        r_state     <= S_SEEK;
                    end else begin
                        r_busy    <= 1'b0;
                        r_channel <= 4'hF;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign channel     = r_channel;
    assign rd_data     = r_rd_data;
    assign valid       = r_valid;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;
    assign scan_done   = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_scan_sequencer
// Brief    : Directed self-checking bench; an inline ADC model answers channels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

    localparam int DISCARD  = 1;
    localparam int TO_CYC   = 100;
    localparam int AVG_LOG2 = 2;
`ifdef ADC_AVG_EN
    localparam int NACQ = 4;
`else
    localparam int NACQ = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] chan_mask = 16'd0;
    logic [3:0]  channel;
    logic        new_sample = 1'b0;
    logic [9:0]  sample = 10'd0;
    logic [3:0]  sample_chan = 4'd0;
    logic [3:0]  rd_ch = 4'd0;
    logic [9:0]  rd_data;
    logic [15:0] valid;
    logic [15:0] timeout_err;
    logic        busy;
    logic        scan_done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    adc_scan_sequencer #(
        .DISCARD     (DISCARD),
        .TIMEOUT_CYC (TO_CYC),
        .AVG_LOG2    (AVG_LOG2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .chan_mask   (chan_mask),
        .channel     (channel),
        .new_sample  (new_sample),
        .sample      (sample),
        .sample_chan (sample_chan),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data),
        .valid       (valid),
        .timeout_err (timeout_err),
        .busy        (busy),
        .scan_done   (scan_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (scan_done === 1'b1) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] ch, input logic [9:0] v);
        new_sample  = 1'b1;
        sample_chan = ch;
        sample      = v;
        @(negedge clk);
        new_sample  = 1'b0;
    endtask

    task automatic acquire(input logic [3:0] ch, input logic [9:0] v);
        repeat (NACQ) send(ch, v);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_chan(input logic [3:0] ch);
        int n = 0;
        while (channel !== ch && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (channel !== ch) begin
            errors++;
            $display("FAIL wait_chan: channel=%h required=%h", channel, ch);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b required=0", busy);
        end
    endtask

    // Returns two cycles after the pulse, by which time a continuous rescan is settling.
    task automatic wait_done();
        int n = 0;
        while (scan_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (scan_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: scan_done=%b required=1", scan_done);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic read_bank(input logic [3:0] ch, output logic [9:0] v);
        rd_ch = ch;
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (channel !== 4'hF || busy !== 1'b0 || scan_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: channel=%h busy=%b done=%b required F/0/0", channel, busy, scan_done);
        end
        checks++;
        if (valid !== 16'd0 || timeout_err !== 16'd0 || rd_data !== 10'd0) begin
            errors++;
            $display("FAIL reset_data: valid=%h terr=%h rd=%h required 0/0/0", valid, timeout_err, rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_mask();
        int d0 = done_cnt;
        chan_mask = 16'h8000;
        pulse_start();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || (done_cnt - d0) !== 0) begin
            errors++;
            $display("FAIL zero_mask: busy=%b dones=%0d required 0/0", busy, done_cnt - d0);
        end
    endtask

    task automatic test_basic_scan();
        logic [9:0] v;
        int d0 = done_cnt;
        chan_mask = 16'h0003;
        pulse_start();
        wait_chan(4'd0);
        send(4'd0, 10'h100);
        acquire(4'd0, 10'h155);
        wait_chan(4'd1);
        send(4'd0, 10'h3FF);
        send(4'd1, 10'h200);
        acquire(4'd1, 10'h2AA);
        wait_idle();
        checks++;
        if ((done_cnt - d0) !== 1 || channel !== 4'hF) begin
            errors++;
            $display("FAIL basic_done: dones=%0d channel=%h required 1/F", done_cnt - d0, channel);
        end
        checks++;
        if (valid !== 16'h0003 || timeout_err !== 16'd0) begin
            errors++;
            $display("FAIL basic_flags: valid=%h terr=%h required 0003/0000", valid, timeout_err);
        end
        read_bank(4'd0, v);
        checks++;
        if (v !== 10'h155) begin
            errors++;
            $display("FAIL basic_bank0: got=%h required=155", v);
        end
        read_bank(4'd1, v);
        checks++;
        if (v !== 10'h2AA) begin
            errors++;
            $display("FAIL stale_bank1: got=%h required=2AA", v);
        end
        read_bank(4'hF, v);
        checks++;
        if (v !== 10'd0) begin
            errors++;
            $display("FAIL rd_ch15: got=%h required=000", v);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] v;
        int d0 = done_cnt;
        chan_mask = 16'h0005;
        pulse_start();
        wait_chan(4'd0);
        send(4'd0, 10'h011);
        acquire(4'd0, 10'h0AA);
        wait_chan(4'd2);
        repeat (TO_CYC - 1) @(negedge clk);
        checks++;
        if (timeout_err !== 16'd0) begin
            errors++;
            $display("FAIL timeout_early: terr=%h required=0000", timeout_err);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 16'h0004) begin
            errors++;
            $display("FAIL timeout_set: terr=%h required=0004", timeout_err);
        end
        wait_idle();
        checks++;
        if (valid !== 16'h0003 || (done_cnt - d0) !== 1) begin
            errors++;
            $display("FAIL timeout_valid: valid=%h dones=%0d required 0003/1", valid, done_cnt - d0);
        end
        read_bank(4'd0, v);
        checks++;
        if (v !== 10'h0AA) begin
            errors++;
            $display("FAIL timeout_bank0: got=%h required=0AA", v);
        end
    endtask

    task automatic test_match_at_timeout();
        logic [9:0] v;
        chan_mask = 16'h0008;
        pulse_start();
        wait_chan(4'd3);
        send(4'd3, 10'h001);
        repeat (TO_CYC - NACQ - 1) @(negedge clk);
        acquire(4'd3, 10'h1C3);
        wait_idle();
        checks++;
        if (timeout_err !== 16'h0004 || valid !== 16'h000B) begin
            errors++;
            $display("FAIL match_wins: terr=%h valid=%h required 0004/000B", timeout_err, valid);
        end
        read_bank(4'd3, v);
        checks++;
        if (v !== 10'h1C3) begin
            errors++;
            $display("FAIL match_wins_bank3: got=%h required=1C3", v);
        end
    endtask

    task automatic test_continuous();
        logic [9:0] v;
        int d0 = done_cnt;
        chan_mask  = 16'h0001;
        continuous = 1'b1;
        pulse_start();
        wait_chan(4'd0);
        for (int k = 0; k < 3; k++) begin
            send(4'd0, 10'h001);
            acquire(4'd0, 10'h040 + 10'(k));
            wait_done();
            checks++;
            if (busy !== 1'b1 || channel !== 4'd0) begin
                errors++;
                $display("FAIL cont_busy: iter=%0d busy=%b channel=%h required 1/0", k, busy, channel);
            end
        end
        continuous = 1'b0;
        send(4'd0, 10'h001);
        acquire(4'd0, 10'h050);
        wait_done();
        checks++;
        if (busy !== 1'b0 || channel !== 4'hF || (done_cnt - d0) !== 4) begin
            errors++;
            $display("FAIL cont_stop: busy=%b channel=%h dones=%0d required 0/F/4", busy, channel, done_cnt - d0);
        end
        read_bank(4'd0, v);
        checks++;
        if (v !== 10'h050) begin
            errors++;
            $display("FAIL cont_bank0: got=%h required=050", v);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [9:0] v;
        chan_mask = 16'h0001;
        rd_ch     = 4'd0;
        pulse_start();
        wait_chan(4'd0);
        send(4'd0, 10'h001);
        checks++;
        if (rd_data !== 10'h050) begin
            errors++;
            $display("FAIL pre_reset_rd: got=%h required=050", rd_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (channel !== 4'hF || busy !== 1'b0 || valid !== 16'd0 || rd_data !== 10'd0 || timeout_err !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: channel=%h busy=%b valid=%h rd=%h terr=%h required F/0/0/0/0",
                     channel, busy, valid, rd_data, timeout_err);
        end
        read_bank(4'd0, v);
        checks++;
        if (v !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_bank0: got=%h required=000", v);
        end
    endtask

    task automatic test_store_value();
        logic [9:0] v;
        logic [9:0] exp_v;
        chan_mask = 16'h0001;
        pulse_start();
        wait_chan(4'd0);
        send(4'd0, 10'h3FF);
`ifdef ADC_AVG_EN
        send(4'd0, 10'd100);
        send(4'd0, 10'd101);
        send(4'd0, 10'd102);
        send(4'd0, 10'd103);
        exp_v = 10'd101;
`else
        send(4'd0, 10'd123);
        exp_v = 10'd123;
`endif
        wait_idle();
        read_bank(4'd1, v);
        rd_ch = 4'd0;
        checks++;
        if (rd_data !== 10'd0) begin
            errors++;
            $display("FAIL rd_latency: got=%h required=000", rd_data);
        end
        @(negedge clk);
        checks++;
        if (rd_data !== exp_v || valid !== 16'h0001) begin
            errors++;
            $display("FAIL store_value: rd=%0d valid=%h required %0d/0001", rd_data, valid, exp_v);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_zero_mask();
        test_basic_scan();
        test_timeout();
        test_match_at_timeout();
        test_continuous();
        test_reset_mid_scan();
        test_store_value();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
